ft245_sff_ctrl: RTL and testbench



---
 rtl/ft245_sff_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_ft245_sff_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ft245_sff_ctrl.sv
// FT245 synchronous-FIFO link controller: arbitrates host reads (Rx byte stream) against
// buffered egress writes (Tx FIFO), with burst limiting and a turnaround cycle between directions.
module ft245_sff_ctrl #(
  parameter int unsigned TX_DEPTH_LOG2 = 4,
  parameter int unsigned BURST_MAX     = 64
) (
  input  logic       Clk,
  input  logic       ARst,
  input  logic       RXFn,
  input  logic       TXEn,
  input  logic [7:0] DIn,
  output logic [7:0] DOut,
  output logic       DOe,
  output logic       RDn,
  output logic       WRn,
  output logic       OEn,
  output logic       RxValid,
  output logic [7:0] RxData,
  input  logic       TxValid,
  input  logic [7:0] TxData,
  output logic       TxFull,
  output logic       TxOvf
);
  localparam int unsigned Depth  = 2 ** TX_DEPTH_LOG2;
  localparam int unsigned PtrW   = TX_DEPTH_LOG2;
  localparam int unsigned CntW   = TX_DEPTH_LOG2 + 1;
  localparam int unsigned BurstW = $clog2(BURST_MAX + 1);
  localparam logic [BurstW-1:0] BurstLast = BurstW'(BURST_MAX);

  typedef enum logic [1:0] {StIdle, StRdOe, StRd, StWr} state_e;

  state_e            state_q, state_d;
  logic              rdn_q, rdn_d, wrn_q, wrn_d, oen_q, oen_d, doe_q, doe_d;
  logic [7:0]        dout_q, dout_d;
  logic              rx_valid_q, rx_valid_d;
  logic [7:0]        rx_data_q, rx_data_d;
  logic [BurstW-1:0] burst_q, burst_d, burst_inc;
  logic              last_rd_q, last_rd_d;

  logic [7:0]        mem_q [Depth];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q, rd_ptr_inc;
  logic [CntW-1:0]   count_q;
  logic              ovf_q;
  logic              push, pop, want_rd, want_wr;

  // Count never exceeds Depth, so its MSB alone marks full.
  assign TxFull     = count_q[CntW-1];
  assign TxOvf      = ovf_q;
  assign push       = TxValid && !TxFull;
  assign want_rd    = !RXFn;
  assign want_wr    = (count_q != '0) && !TXEn;
  assign burst_inc  = burst_q + BurstW'(1);
  assign rd_ptr_inc = rd_ptr_q + PtrW'(1);

  always_comb begin
    state_d    = state_q;
    rdn_d      = rdn_q;
    wrn_d      = wrn_q;
    oen_d      = oen_q;
    doe_d      = doe_q;
    dout_d     = dout_q;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;
    burst_d    = burst_q;
    last_rd_d  = last_rd_q;
    pop        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (want_rd && (!want_wr || !last_rd_q)) begin
          state_d = StRdOe;
          oen_d   = 1'b0;
        end else if (want_wr) begin
          state_d = StWr;
          wrn_d   = 1'b0;
          doe_d   = 1'b1;
          dout_d  = mem_q[rd_ptr_q];
          burst_d = '0;
        end
      end
      StRdOe: begin
        state_d = StRd;
        rdn_d   = 1'b0;
        burst_d = '0;
      end
      StRd: begin
        if (RXFn) begin
          state_d   = StIdle;
          rdn_d     = 1'b1;
          oen_d     = 1'b1;
          last_rd_d = 1'b1;
        end else if (!rdn_q) begin
          rx_valid_d = 1'b1;
          rx_data_d  = DIn;
          burst_d    = burst_inc;
          if (burst_inc == BurstLast) begin
            state_d   = StIdle;
            rdn_d     = 1'b1;
            oen_d     = 1'b1;
            last_rd_d = 1'b1;
          end
        end
      end
      StWr: begin
        if (TXEn) begin
          // Host stalled: give the bus back, keep the head byte queued.
          state_d   = StIdle;
          wrn_d     = 1'b1;
          doe_d     = 1'b0;
          last_rd_d = 1'b0;
        end else if (!wrn_q) begin
          pop     = 1'b1;
          burst_d = burst_inc;
          if (count_q == CntW'(1) || burst_inc == BurstLast) begin
            state_d   = StIdle;
            wrn_d     = 1'b1;
            doe_d     = 1'b0;
            last_rd_d = 1'b0;
          end else begin
            dout_d = mem_q[rd_ptr_inc];
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (ARst) begin
      state_q    <= StIdle;
      rdn_q      <= 1'b1;
      wrn_q      <= 1'b1;
      oen_q      <= 1'b1;
      doe_q      <= 1'b0;
      dout_q     <= 8'h00;
      rx_valid_q <= 1'b0;
      rx_data_q  <= 8'h00;
      burst_q    <= '0;
      last_rd_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rdn_q      <= rdn_d;
      wrn_q      <= wrn_d;
      oen_q      <= oen_d;
      doe_q      <= doe_d;
      dout_q     <= dout_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      burst_q    <= burst_d;
      last_rd_q  <= last_rd_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (ARst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_inc;
      if (push && !pop)      count_q <= count_q + CntW'(1);
      else if (!push && pop) count_q <= count_q - CntW'(1);
      if (TxValid && TxFull) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (push) mem_q[wr_ptr_q] <= TxData;
  end

  assign RDn     = rdn_q;
  assign WRn     = wrn_q;
  assign OEn     = oen_q;
  assign DOe     = doe_q;
  assign DOut    = dout_q;
  assign RxValid = rx_valid_q;
  assign RxData  = rx_data_q;

endmodule

// File: tb/tb_ft245_sff_ctrl.sv
// Directed bench for ft245_sff_ctrl: reads, writes, stalls, arbitration, overflow, reset.
module tb_ft245_sff_ctrl;
  logic       Clk = 1'b0;
  logic       ARst = 1'b1;
  logic       RXFn = 1'b1;
  logic       TXEn = 1'b1;
  logic [7:0] DIn = 8'h00;
  logic [7:0] DOut;
  logic       DOe, RDn, WRn, OEn, RxValid;
  logic [7:0] RxData;
  logic       TxValid = 1'b0;
  logic [7:0] TxData = 8'h00;
  logic       TxFull, TxOvf;

  int n_checks = 0;
  int n_errors = 0;
  bit mon_en = 1'b0;

  ft245_sff_ctrl #(.TX_DEPTH_LOG2(4), .BURST_MAX(64)) dut (
    .Clk(Clk), .ARst(ARst), .RXFn(RXFn), .TXEn(TXEn), .DIn(DIn), .DOut(DOut), .DOe(DOe),
    .RDn(RDn), .WRn(WRn), .OEn(OEn), .RxValid(RxValid), .RxData(RxData),
    .TxValid(TxValid), .TxData(TxData), .TxFull(TxFull), .TxOvf(TxOvf)
  );

  always #5 Clk = ~Clk;

  // Bus contention guard: DOe and OEn must never be active together.
  always @(negedge Clk) begin
    if (mon_en && !ARst) begin
      n_checks++;
      if (DOe && !OEn) begin
        n_errors++;
        $display("FAIL turnaround: DOe=%b OEn=%b both active at %0t", DOe, OEn, $time);
      end
    end
  end

  initial begin
    #100us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic push_bytes(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      TxValid = 1'b1;
      TxData  = first + 8'(i);
      tick;
    end
    TxValid = 1'b0;
  endtask

  task automatic test_reset;
    ARst = 1'b1; RXFn = 1'b1; TXEn = 1'b1; TxValid = 1'b0;
    tick; tick;
    n_checks++;
    if ({RDn, WRn, OEn, DOe} !== 4'b1110) begin
      n_errors++; $display("FAIL reset_strobes: got %b want 1110", {RDn, WRn, OEn, DOe});
    end
    n_checks++;
    if ({DOut, RxData, RxValid, TxFull, TxOvf} !== 19'h0) begin
      n_errors++;
      $display("FAIL reset_data: DOut=%h RxData=%h RxValid=%b TxFull=%b TxOvf=%b want all 0",
               DOut, RxData, RxValid, TxFull, TxOvf);
    end
    ARst = 1'b0;
    mon_en = 1'b1;
    tick;
  endtask

  task automatic test_read;
    RXFn = 1'b0; DIn = 8'h10;
    tick;
    n_checks++;
    if ({OEn, RDn, RxValid} !== 3'b010) begin
      n_errors++; $display("FAIL read_oe: OEn,RDn,RxValid=%b want 010", {OEn, RDn, RxValid});
    end
    tick;
    n_checks++;
    if ({OEn, RDn, RxValid} !== 3'b000) begin
      n_errors++; $display("FAIL read_rd: OEn,RDn,RxValid=%b want 000", {OEn, RDn, RxValid});
    end
    for (int i = 0; i < 5; i++) begin
      tick;
      n_checks++;
      if (RxValid !== 1'b1 || RxData !== 8'h10 + 8'(i)) begin
        n_errors++;
        $display("FAIL read_byte%0d: RxValid=%b RxData=%h want 1/%h", i, RxValid, RxData,
                 8'h10 + 8'(i));
      end
      DIn = 8'h11 + 8'(i);
      if (i == 4) RXFn = 1'b1;
    end
    tick;
    n_checks++;
    if ({OEn, RDn, RxValid} !== 3'b110) begin
      n_errors++; $display("FAIL read_exit: OEn,RDn,RxValid=%b want 110", {OEn, RDn, RxValid});
    end
    tick;
  endtask

  task automatic test_write;
    RXFn = 1'b1; TXEn = 1'b1;
    push_bytes(8'hA0, 3);
    TXEn = 1'b0;
    tick;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({WRn, DOe} !== 2'b01 || DOut !== 8'hA0 + 8'(i)) begin
        n_errors++;
        $display("FAIL write_byte%0d: WRn,DOe=%b DOut=%h want 01/%h", i, {WRn, DOe}, DOut,
                 8'hA0 + 8'(i));
      end
      tick;
    end
    n_checks++;
    if ({WRn, DOe} !== 2'b10) begin
      n_errors++; $display("FAIL write_exit: WRn,DOe=%b want 10", {WRn, DOe});
    end
    tick;
    n_checks++;
    if (WRn !== 1'b1) begin
      n_errors++; $display("FAIL write_empty_idle: WRn=%b want 1", WRn);
    end
    TXEn = 1'b1;
  endtask

  task automatic test_txe_stall;
    push_bytes(8'hB0, 4);
    TXEn = 1'b0;
    tick;
    tick;
    n_checks++;
    if (WRn !== 1'b0 || DOut !== 8'hB1) begin
      n_errors++; $display("FAIL stall_pre: WRn=%b DOut=%h want 0/b1", WRn, DOut);
    end
    TXEn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      n_checks++;
      if ({WRn, DOe} !== 2'b10 || DOut !== 8'hB1) begin
        n_errors++;
        $display("FAIL stall_hold%0d: WRn,DOe=%b DOut=%h want 10/b1", i, {WRn, DOe}, DOut);
      end
    end
    TXEn = 1'b0;
    tick;
    for (int i = 1; i < 4; i++) begin
      n_checks++;
      if (WRn !== 1'b0 || DOut !== 8'hB0 + 8'(i)) begin
        n_errors++;
        $display("FAIL stall_resume%0d: WRn=%b DOut=%h want 0/%h", i, WRn, DOut, 8'hB0 + 8'(i));
      end
      tick;
    end
    n_checks++;
    if ({WRn, DOe} !== 2'b10) begin
      n_errors++; $display("FAIL stall_exit: WRn,DOe=%b want 10", {WRn, DOe});
    end
    TXEn = 1'b1;
    tick;
  endtask

  task automatic test_arbitration;
    int  rx_cnt;
    bit  done;
    push_bytes(8'hC0, 4);
    DIn = 8'h5A; RXFn = 1'b0; TXEn = 1'b0;
    tick;
    n_checks++;
    if ({OEn, RDn, DOe, WRn} !== 4'b0101) begin
      n_errors++; $display("FAIL arb_read_first: OEn,RDn,DOe,WRn=%b want 0101", {OEn, RDn, DOe, WRn});
    end
    tick;
    rx_cnt = 0;
    done   = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      tick;
      if (RxValid) rx_cnt++;
      if (RDn) done = 1'b1;
    end
    n_checks++;
    if (!done || rx_cnt != 64) begin
      n_errors++; $display("FAIL arb_burst_cap: done=%b bytes=%0d want 1/64", done, rx_cnt);
    end
    n_checks++;
    if ({OEn, DOe, RDn} !== 3'b101) begin
      n_errors++; $display("FAIL arb_idle1: OEn,DOe,RDn=%b want 101", {OEn, DOe, RDn});
    end
    tick;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({WRn, DOe, OEn} !== 3'b011 || DOut !== 8'hC0 + 8'(i)) begin
        n_errors++;
        $display("FAIL arb_write%0d: WRn,DOe,OEn=%b DOut=%h want 011/%h", i, {WRn, DOe, OEn},
                 DOut, 8'hC0 + 8'(i));
      end
      tick;
    end
    n_checks++;
    if ({WRn, DOe, OEn} !== 3'b101) begin
      n_errors++; $display("FAIL arb_idle2: WRn,DOe,OEn=%b want 101", {WRn, DOe, OEn});
    end
    tick;
    n_checks++;
    if ({OEn, DOe} !== 2'b00) begin
      n_errors++; $display("FAIL arb_read_again: OEn,DOe=%b want 00", {OEn, DOe});
    end
    RXFn = 1'b1;
    tick;
    tick;
    n_checks++;
    if ({RDn, OEn} !== 2'b11) begin
      n_errors++; $display("FAIL arb_read_end: RDn,OEn=%b want 11", {RDn, OEn});
    end
    TXEn = 1'b1;
    tick;
  endtask

  task automatic test_overflow;
    RXFn = 1'b1; TXEn = 1'b1;
    push_bytes(8'h20, 15);
    n_checks++;
    if (TxFull !== 1'b0) begin
      n_errors++; $display("FAIL ovf_15: TxFull=%b want 0", TxFull);
    end
    push_bytes(8'h2F, 1);
    n_checks++;
    if ({TxFull, TxOvf} !== 2'b10) begin
      n_errors++; $display("FAIL ovf_16: TxFull,TxOvf=%b want 10", {TxFull, TxOvf});
    end
    push_bytes(8'hEE, 1);
    n_checks++;
    if ({TxFull, TxOvf} !== 2'b11) begin
      n_errors++; $display("FAIL ovf_17: TxFull,TxOvf=%b want 11", {TxFull, TxOvf});
    end
    TXEn = 1'b0;
    tick;
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (WRn !== 1'b0 || DOut !== 8'h20 + 8'(i)) begin
        n_errors++;
        $display("FAIL ovf_drain%0d: WRn=%b DOut=%h want 0/%h", i, WRn, DOut, 8'h20 + 8'(i));
      end
      tick;
    end
    n_checks++;
    if ({WRn, DOe, TxFull, TxOvf} !== 4'b1001) begin
      n_errors++;
      $display("FAIL ovf_after: WRn,DOe,TxFull,TxOvf=%b want 1001", {WRn, DOe, TxFull, TxOvf});
    end
    TXEn = 1'b1;
    tick;
  endtask

  task automatic test_arst_mid_burst;
    push_bytes(8'h90, 2);
    RXFn = 1'b0; DIn = 8'h77;
    tick; tick; tick;
    n_checks++;
    if (RxValid !== 1'b1 || RxData !== 8'h77) begin
      n_errors++; $display("FAIL arst_inburst: RxValid=%b RxData=%h want 1/77", RxValid, RxData);
    end
    ARst = 1'b1;
    tick;
    n_checks++;
    if ({RDn, OEn, RxValid, TxOvf, TxFull} !== 5'b11000 || DOut !== 8'h00) begin
      n_errors++;
      $display("FAIL arst_state: RDn,OEn,RxValid,TxOvf,TxFull=%b DOut=%h want 11000/00",
               {RDn, OEn, RxValid, TxOvf, TxFull}, DOut);
    end
    RXFn = 1'b1; TXEn = 1'b0;
    ARst = 1'b0;
    tick; tick;
    n_checks++;
    if ({WRn, DOe} !== 2'b10) begin
      n_errors++; $display("FAIL arst_fifo_empty: WRn,DOe=%b want 10", {WRn, DOe});
    end
    TXEn = 1'b1; RXFn = 1'b0; DIn = 8'h42;
    tick; tick; tick;
    n_checks++;
    if (RxValid !== 1'b1 || RxData !== 8'h42) begin
      n_errors++; $display("FAIL arst_resume: RxValid=%b RxData=%h want 1/42", RxValid, RxData);
    end
    RXFn = 1'b1;
    tick;
    n_checks++;
    if ({RDn, OEn} !== 2'b11) begin
      n_errors++; $display("FAIL arst_resume_exit: RDn,OEn=%b want 11", {RDn, OEn});
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_txe_stall();
    test_arbitration();
    test_overflow();
    test_arst_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
